// File: rtl/imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// imem_port_arbiter
//
// Shares the single instruction-memory read port between the fetch unit
// (port 0) and a secondary master such as debug or a program loader (port 1).
// Only one read can be in flight at a time. Requests are arbitrated
// round-robin, and each returned word is routed back to the port that issued
// the request. A branch flush drops a pending fetch response. A memory that
// never answers is timed out and a NOP word is returned in its place.
//
// Ports
//   clk, rst                   rising-edge clock, synchronous active-high reset
//   req0_valid/addr/ready      fetch-unit request handshake (ready is
//                              combinational in IDLE)
//   rsp0_valid/data            fetch-unit response (valid is a 1-cycle pulse)
//   flush0                     branch flush; cancels the port 0 response
//   req1_* / rsp1_*            secondary-master request/response (no flush)
//   mem_addr, mem_read         memory request, held stable while BUSY
//   mem_data, mem_ready        memory read data / data-valid strobe
//   busy                       a transaction is in flight (BUSY or RESP)
//   timeout_err                1-cycle pulse in the RESP cycle of a timeout
// -----------------------------------------------------------------------------
module imem_port_arbiter #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                TIMEOUT     = 64,
  parameter logic [DATA_W-1:0] TIMEOUT_RSP = DATA_W'(32'h0000_0013)
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              flush0,

  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,

  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Counter value seen in the last BUSY cycle before the timeout fires.
  // TIMEOUT is limited to 2..255, so 8 bits are enough.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic              owner;       // port that owns the in-flight transaction
  logic              last_grant;  // port granted most recently
  logic              cancel;      // port 0 response dropped by an earlier flush
  logic [7:0]        cnt;
  logic [DATA_W-1:0] cap_data;    // word captured for the RESP cycle
  logic [DATA_W-1:0] hold0;       // last word delivered on each port
  logic [DATA_W-1:0] hold1;

  logic elig0;
  logic elig1;
  logic grant0;
  logic grant1;

  // A flushed fetch request is not eligible, which leaves port 1 free to win.
  assign elig0 = req0_valid & ~flush0;
  assign elig1 = req1_valid;

  // Port 1 wins if it is the only requester, or if both request and port 0
  // was granted last.
  assign grant1 = elig1 & (~elig0 | ~last_grant);
  assign grant0 = elig0 & ~grant1;

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;

  // A flush that arrives in the RESP cycle itself must still suppress the
  // pulse, so the response valids are decoded from state rather than
  // registered.
  assign rsp0_valid = (state == RESP) & ~owner & ~cancel & ~flush0;
  assign rsp1_valid = (state == RESP) & owner;

  assign rsp0_data = rsp0_valid ? cap_data : hold0;
  assign rsp1_data = rsp1_valid ? cap_data : hold1;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      cancel      <= 1'b0;
      cnt         <= '0;
      mem_read    <= 1'b0;
      mem_addr    <= '0;
      timeout_err <= 1'b0;
      cap_data    <= '0;
      hold0       <= '0;
      hold1       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            owner      <= grant1;
            last_grant <= grant1;
            mem_addr   <= grant1 ? req1_addr : req0_addr;
            mem_read   <= 1'b1;
            cancel     <= 1'b0;
            cnt        <= '0;
            state      <= BUSY;
          end
        end

        BUSY: begin
          // The memory read runs to completion even after a flush; only the
          // response is dropped.
          if (flush0 && !owner) begin
            cancel <= 1'b1;
          end
          // mem_ready is checked first so real data wins over a timeout that
          // expires in the same cycle.
          if (mem_ready) begin
            cap_data <= mem_data;
            cnt      <= '0;
            mem_read <= 1'b0;
            state    <= RESP;
          end else if (cnt == CNT_LAST) begin
            cap_data    <= TIMEOUT_RSP;
            timeout_err <= 1'b1;
            cnt         <= '0;
            mem_read    <= 1'b0;
            state       <= RESP;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        RESP: begin
          if (rsp0_valid) begin
            hold0 <= cap_data;
          end
          if (rsp1_valid) begin
            hold1 <= cap_data;
          end
          cancel      <= 1'b0;
          timeout_err <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_port_arbiter
//
// Bench for imem_port_arbiter (TIMEOUT = 8). A transaction-level reference
// model tracks, per accepted request, its owner, its address, the latency the
// bench's memory will answer with, and how many cycles the request has been
// outstanding. The model predicts every output in every cycle from those
// quantities. Directed sequences cover the listed corner cases, and a long
// randomized run follows them.
// -----------------------------------------------------------------------------
module tb_imem_port_arbiter;

  localparam int          ADDR_W  = 32;
  localparam int          DATA_W  = 32;
  localparam int          TIMEOUT = 8;
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, rsp0_valid, flush0;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] rsp0_data;
  logic              req1_valid, req1_ready, rsp1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] rsp1_data;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read, mem_ready;
  logic [DATA_W-1:0] mem_data;
  logic              busy, timeout_err;

  always #10 clk = ~clk;

  imem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .TIMEOUT    (TIMEOUT),
    .TIMEOUT_RSP(NOP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_ready (req0_ready),
    .rsp0_valid (rsp0_valid),
    .rsp0_data  (rsp0_data),
    .flush0     (flush0),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_ready (req1_ready),
    .rsp1_valid (rsp1_valid),
    .rsp1_data  (rsp1_data),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_txn;          // a request has been accepted and not yet answered
  int          m_age;          // cycles since acceptance
  int          m_lat;          // cycle index (from 0) at which memory answers
  int          m_busy_len;     // number of cycles the memory read is held
  bit          m_owner, m_drop, m_last;
  logic [31:0] m_addr, m_word, m_hold0, m_hold1;

  // memory / stimulus controls
  bit          use_rand = 1'b0;
  bit          noise    = 1'b0;  // random mem_ready when nothing is outstanding
  bit          idle_rdy = 1'b0;  // fixed mem_ready when nothing is outstanding
  int          dir_lat  = 1;
  logic [31:0] dir_data = 32'h0;

  // snapshot of DUT outputs from the most recent cycle
  logic        s_r0rdy, s_r1rdy, s_rv0, s_rv1, s_mread, s_busy, s_to;
  logic [31:0] s_rd0, s_rd1, s_maddr;

  task automatic model_reset();
    m_txn   = 1'b0;
    m_age   = 0;
    m_last  = 1'b1;
    m_drop  = 1'b0;
    m_hold0 = '0;
    m_hold1 = '0;
  endtask

  // Called at a falling edge with the request inputs already driven. Drives
  // the memory, checks every output, advances the model across the rising
  // edge, and returns at the next falling edge.
  task automatic step();
    bit          e0, e1, w0, w1, in_busy, in_resp, ev0, ev1, to;
    logic [31:0] res;
    e0      = req0_valid && !flush0;
    e1      = req1_valid;
    in_busy = m_txn && (m_age < m_busy_len);
    in_resp = m_txn && (m_age == m_busy_len);
    w0 = 1'b0;
    w1 = 1'b0;
    if (!m_txn) begin
      if (e0 && e1) begin
        if (m_last) w0 = 1'b1; else w1 = 1'b1;
      end else begin
        w0 = e0;
        w1 = e1;
      end
    end
    if (in_busy) begin
      mem_ready = (m_lat < TIMEOUT) && (m_age == m_lat);
      mem_data  = mem_ready ? m_word : $urandom();
    end else begin
      mem_ready = noise ? 1'($urandom_range(0, 1)) : idle_rdy;
      mem_data  = $urandom();
    end
    to  = in_resp && (m_lat >= TIMEOUT);
    res = to ? NOP : m_word;
    ev0 = in_resp && !m_owner && !m_drop && !flush0;
    ev1 = in_resp && m_owner;
    #1;
    s_r0rdy = req0_ready;  s_r1rdy = req1_ready;
    s_rv0   = rsp0_valid;  s_rv1   = rsp1_valid;
    s_rd0   = rsp0_data;   s_rd1   = rsp1_data;
    s_mread = mem_read;    s_maddr = mem_addr;
    s_busy  = busy;        s_to    = timeout_err;
    chk("req0_ready", s_r0rdy, w0);
    chk("req1_ready", s_r1rdy, w1);
    chk("busy", s_busy, m_txn);
    chk("mem_read", s_mread, in_busy);
    if (in_busy) chk("mem_addr", s_maddr, m_addr);
    chk("rsp0_valid", s_rv0, ev0);
    chk("rsp1_valid", s_rv1, ev1);
    chk("rsp0_data", s_rd0, ev0 ? res : m_hold0);
    chk("rsp1_data", s_rd1, ev1 ? res : m_hold1);
    chk("timeout_err", s_to, to);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (!m_txn) begin
      if (w0 || w1) begin
        m_txn   = 1'b1;
        m_age   = 0;
        m_owner = w1;
        m_last  = w1;
        m_drop  = 1'b0;
        m_addr  = w1 ? req1_addr : req0_addr;
        m_lat   = use_rand ? $urandom_range(0, TIMEOUT + 2) : dir_lat;
        m_word  = use_rand ? $urandom() : dir_data;
        m_busy_len = (m_lat < TIMEOUT) ? m_lat + 1 : TIMEOUT;
      end
    end else if (in_busy) begin
      if (flush0 && !m_owner) m_drop = 1'b1;
      m_age++;
    end else begin
      if (ev0) m_hold0 = res;
      if (ev1) m_hold1 = res;
      m_txn = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic r0, input logic [31:0] a0, input logic f0,
                       input logic r1, input logic [31:0] a1);
    req0_valid = r0; req0_addr = a0; flush0 = f0;
    req1_valid = r1; req1_addr = a1;
  endtask

  task automatic idle_steps(input int n);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    mem_ready = 1'b0;
    mem_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Arbitration table, evaluated in the reset state (port 0 wins ties).
  typedef struct packed {
    logic r0, f0, r1, exp0, exp1;
  } arb_vec_t;

  arb_vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          cnt, pulses;
    logic [31:0] got_data;
    logic        got_to;
    bit          act_grant [$];

    tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    do_reset();

    // Reset values
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk("rst_rsp0_data", rsp0_data, 32'h0);
    chk("rst_rsp1_data", rsp1_data, 32'h0);
    chk("rst_timeout_err", timeout_err, 1'b0);

    // Combinational arbitration table, applied within one low clock phase
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].r0, 32'h10, tbl[i].f0, tbl[i].r1, 32'h20);
      #1;
      chk($sformatf("arb%0d_ready0", i), req0_ready, tbl[i].exp0);
      chk($sformatf("arb%0d_ready1", i), req1_ready, tbl[i].exp1);
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);

    // Single fetch: latency 1
    dir_lat = 1; dir_data = 32'hDEAD_BEEF;
    drive(1'b1, 32'h40, 1'b0, 1'b0, 32'h0);
    step();
    chk("fetch_ready", s_r0rdy, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("fetch_mem_read", s_mread, 1'b1);
      chk("fetch_mem_addr", s_maddr, 32'h40);
    end
    step();
    chk("fetch_rsp_valid", s_rv0, 1'b1);
    chk("fetch_rsp_data", s_rd0, 32'hDEAD_BEEF);
    chk("fetch_rsp1_quiet", s_rv1, 1'b0);
    step();
    chk("fetch_idle", s_busy, 1'b0);
    chk("fetch_hold", s_rd0, 32'hDEAD_BEEF);

    // Contention from reset: grants alternate 0,1,0,1
    do_reset();
    dir_lat = 1; dir_data = 32'h5A5A_0001;
    drive(1'b1, 32'h100, 1'b0, 1'b1, 32'h200);
    for (int i = 0; i < 16; i++) begin
      step();
      if (s_r0rdy || s_r1rdy) act_grant.push_back(s_r1rdy);
    end
    chk("cont_grant_count", act_grant.size(), 4);
    for (int i = 0; i < act_grant.size() && i < 4; i++)
      chk($sformatf("cont_grant%0d", i), act_grant[i], i % 2);
    idle_steps(4);

    // Flush during BUSY drops the fetch response
    dir_lat = 3; dir_data = 32'h1111_2222;
    drive(1'b1, 32'h80, 1'b0, 1'b0, 32'h0);
    step();
    chk("flush_accept", s_r0rdy, 1'b1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, (i == 1), 1'b0, 32'h0);
      step();
      if (s_rv0) pulses++;
    end
    chk("flush_no_rsp", pulses, 0);
    dir_lat = 1; dir_data = 32'h1234_5678;
    drive(1'b1, 32'h84, 1'b0, 1'b0, 32'h0);
    step();
    chk("post_flush_accept", s_r0rdy, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    pulses = 0;
    got_data = '0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (s_rv0) begin pulses++; got_data = s_rd0; end
    end
    chk("post_flush_rsp", pulses, 1);
    chk("post_flush_data", got_data, 32'h1234_5678);

    // Timeout: memory never answers
    dir_lat = 1000; dir_data = 32'hFFFF_FFFF;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h300);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cnt = 0; got_to = 1'b0; got_data = '0; pulses = 0;
    for (int i = 0; i < 20 && pulses == 0; i++) begin
      step();
      if (s_mread) cnt++;
      if (s_rv1) begin pulses = 1; got_data = s_rd1; got_to = s_to; end
    end
    chk("to_busy_cycles", cnt, TIMEOUT);
    chk("to_rsp_seen", pulses, 1);
    chk("to_err", got_to, 1'b1);
    chk("to_data", got_data, NOP);
    step();
    chk("to_idle", s_busy, 1'b0);

    // mem_ready in the final BUSY cycle beats the timeout
    dir_lat = TIMEOUT - 1; dir_data = 32'h0000_CAFE;
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h304);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    cnt = 0; got_to = 1'b1; got_data = '0; pulses = 0;
    for (int i = 0; i < 20 && pulses == 0; i++) begin
      step();
      if (s_mread) cnt++;
      if (s_rv1) begin pulses = 1; got_data = s_rd1; got_to = s_to; end
    end
    chk("race_busy_cycles", cnt, TIMEOUT);
    chk("race_no_err", got_to, 1'b0);
    chk("race_data", got_data, 32'h0000_CAFE);
    idle_steps(1);

    // Reset mid-transaction, then a late mem_ready
    dir_lat = 1000;
    drive(1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
    step();
    idle_steps(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_rdy = 1'b1;
    pulses = 0; cnt = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (s_rv0 || s_rv1) pulses++;
      if (s_mread) cnt++;
    end
    idle_rdy = 1'b0;
    chk("rst_mid_no_rsp", pulses, 0);
    chk("rst_mid_mem_read", cnt, 0);
    dir_lat = 0; dir_data = 32'h0BAD_F00D;
    drive(1'b1, 32'h600, 1'b0, 1'b1, 32'h700);
    step();
    chk("rst_mid_grant0", s_r0rdy, 1'b1);
    chk("rst_mid_grant1", s_r1rdy, 1'b0);
    idle_steps(3);

    // Flush together with a fetch request in IDLE: port 1 granted
    drive(1'b1, 32'h800, 1'b1, 1'b1, 32'h900);
    step();
    chk("flush_idle_ready0", s_r0rdy, 1'b0);
    chk("flush_idle_ready1", s_r1rdy, 1'b1);
    idle_steps(3);

    // Randomized traffic against the reference model
    use_rand = 1'b1;
    noise    = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 9) < 6), $urandom(), ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 1) == 1), $urandom());
      step();
    end
    rst = 1'b0;
    idle_steps(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
